byte_data_mem: RTL and testbench

Byte-addressable data memory with a request/response handshake, replacing the single-cycle data memory behind the CPU's load/store path. Supports the full RV32I sub-word set (LB/LH/LW/LBU/LHU, SB/SH/SW) with per-byte write strobes, sign/zero extension and misalignment reporting. Depth and read latency are parametrised, so the same block serves the single-cycle core (RD_LAT=1, stalling on `req_ready`) and later multi-cycle/pipelined cores.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/load_align.sv | 34 +++
 rtl/byte_data_mem.sv | 165 ++++++++++++++++
 tb/tb_byte_data_mem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
//  mem_pkg : shared funct3 codes, FSM state type and latency limit for the
//            byte-addressable data memory and its load aligner.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int MAX_RD_LAT = 4;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
//  load_align : picks the addressed byte/half out of a 32-bit word and
//               sign- or zero-extends it according to the RV32I load funct3.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = word[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'h000000, byte_sel};
            F3_HU:   data = {16'h0000, half_sel};
            default: data = word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/byte_data_mem.sv
// ============================================================================
//  byte_data_mem : byte-addressable RV32I data memory with request/response
//                  handshake and parametrised load latency.
//  Option macro BYTE_DATA_MEM_MISALIGN_EN enables misalignment errors.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module byte_data_mem
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int CNT_W = $clog2(MAX_RD_LAT);
    localparam logic [CNT_W-1:0] LOAD_CNT = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        mem [DEPTH];
    logic [31:0]        hold_rdata;

    logic               accept;
    logic [1:0]         size;
    logic [1:0]         off;
    logic               illegal;
    logic               misal;
    logic               err;
    logic [3:0]         strb;
    logic [31:0]        wrep;
    logic [ADDR_W-3:0]  word_addr;
    logic [31:0]        rd_word;
    logic [31:0]        ld_data;

    assign req_ready = (state != ST_WAIT);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;
    assign busy      = (state == ST_WAIT) || ((state == ST_RESP) && accept);
    assign size      = req_funct3[1:0];
    assign word_addr = req_addr[ADDR_W-1:2];
    assign rd_word   = mem[word_addr];
    assign err       = illegal || misal;

`ifdef BYTE_DATA_MEM_MISALIGN_EN
    assign misal = ((size == 2'b01) && req_addr[0]) ||
                   ((size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    // Lane offset is always size-aligned; misaligned requests either error
    // out or are deliberately forced onto the aligned container.
    always_comb begin
        illegal = 1'b1;
        case (req_funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = req_we;
            default:          illegal = 1'b1;
        endcase
        case (size)
            2'b00: begin
                off  = req_addr[1:0];
                strb = 4'b0001 << req_addr[1:0];
                wrep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                off  = {req_addr[1], 1'b0};
                strb = req_addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{req_wdata[15:0]}};
            end
            default: begin
                off  = 2'b00;
                strb = 4'b1111;
                wrep = req_wdata;
            end
        endcase
    end

    load_align u_load_align (
        .word   (rd_word),
        .off    (off),
        .funct3 (req_funct3),
        .data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem[word_addr][8*b +: 8] <= wrep[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    state_nxt = (req_we || err || (RD_LAT == 1)) ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response data is loaded only on the edge entering RESP, so it reads
    // as zero in every other cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hold_rdata <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (state == ST_WAIT) begin
                if (cnt == '0) begin
                    rsp_rdata <= hold_rdata;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
            if (accept) begin
                hold_rdata <= ld_data;
                cnt        <= LOAD_CNT;
                if (err) begin
                    rsp_err <= 1'b1;
                end else if (!req_we && (RD_LAT == 1)) begin
                    rsp_rdata <= ld_data;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_byte_data_mem.sv
// ============================================================================
//  tb_byte_data_mem : directed stimulus with a byte-array reference model and
//                     a per-cycle output comparator for byte_data_mem.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_byte_data_mem;

    localparam int ADDR_W = 10;
    localparam int RD_LAT = 3;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    byte_data_mem #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: byte-level memory plus the one outstanding response.
    bit [7:0]    mbytes [0:1023];
    bit          pend = 1'b0;
    int          resp_cyc = 0;
    logic [31:0] exp_data = '0;
    logic        exp_err = 1'b0;
    int          acc_count = 0;
    int          rsp_count = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_ready();
        return !(pend && cyc <= resp_cyc) || (cyc == resp_cyc);
    endfunction

    task automatic model_accept(input bit we, input logic [2:0] f3, input logic [9:0] a,
                                input logic [31:0] wd);
        int n;
        int base;
        bit legal;
        bit e;
        logic [31:0] v;
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (!we && ((f3 == 3'b100) || (f3 == 3'b101)));
        n = legal ? (1 << f3[1:0]) : 1;
`ifdef BYTE_DATA_MEM_MISALIGN_EN
        e = !legal || ((int'(a) % n) != 0);
`else
        e = !legal;
`endif
        base = int'(a) - (int'(a) % n);
        v = '0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) mbytes[base + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[base + i];
                if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
            end
        end
        exp_data = (we || e) ? 32'h0 : v;
        exp_err  = e;
        resp_cyc = cyc + ((we || e) ? 1 : RD_LAT) - 1;
        pend     = 1'b1;
        acc_count++;
    endtask

    always @(negedge clk) begin
        bit active;
        bit ev;
        active = pend && (cyc <= resp_cyc);
        ev     = active && (cyc == resp_cyc);
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, ev});
        chk("rsp_rdata", rsp_rdata, ev ? exp_data : 32'h0);
        chk("rsp_err",   {31'h0, rsp_err}, {31'h0, ev && exp_err});
        chk("req_ready", {31'h0, req_ready}, {31'h0, !active || ev});
        chk("busy",      {31'h0, busy}, {31'h0, active && (!ev || req_valid)});
        if (rsp_valid === 1'b1) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            rsp_count++;
        end
    end

    task automatic issue(input bit we, input logic [2:0] f3, input logic [9:0] a,
                         input logic [31:0] wd);
        int guard;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        guard = 0;
        while (!model_ready() && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) chk("issue_timeout", 32'(guard), 32'd0);
        @(posedge clk); #1;
        model_accept(we, f3, a, wd);
    endtask

    task automatic expect_rsp(input string name, input int lat,
                              input logic [31:0] data, input logic err);
        int n;
        req_valid = 1'b0;
        n = 0;
        while (rsp_count != acc_count && n < 12) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'(lat));
        chk({name, "_data"}, last_rdata, data);
        chk({name, "_err"}, {31'h0, last_err}, {31'h0, err});
    endtask

    task automatic access(input string name, input bit we, input logic [2:0] f3,
                          input logic [9:0] a, input logic [31:0] wd,
                          input logic [31:0] data, input logic err);
        issue(we, f3, a, wd);
        expect_rsp(name, (we || err) ? 1 : RD_LAT, data, err);
    endtask

    initial begin
        int saved;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        access("sw_dead",  1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h0,        0);
        access("lw_dead",  0, 3'b010, 10'h010, 32'h0,        32'hDEADBEEF, 0);
        access("sb_80",    1, 3'b000, 10'h013, 32'h00000080, 32'h0,        0);
        access("lb_13",    0, 3'b000, 10'h013, 32'h0,        32'hFFFFFF80, 0);
        access("lbu_13",   0, 3'b100, 10'h013, 32'h0,        32'h00000080, 0);
        access("lw_after_sb", 0, 3'b010, 10'h010, 32'h0,     32'h80ADBEEF, 0);
        access("sh_1234",  1, 3'b001, 10'h010, 32'h00001234, 32'h0,        0);
        access("lw_after_sh", 0, 3'b010, 10'h010, 32'h0,     32'h80AD1234, 0);

        access("sw_cafe",  1, 3'b010, 10'h020, 32'hCAFEF00D, 32'h0,        0);
`ifdef BYTE_DATA_MEM_MISALIGN_EN
        access("lw_mis",   0, 3'b010, 10'h011, 32'h0,        32'h0,        1);
        access("sh_mis",   1, 3'b001, 10'h021, 32'h0000FFFF, 32'h0,        1);
        access("lw_20",    0, 3'b010, 10'h020, 32'h0,        32'hCAFEF00D, 0);
`else
        access("lw_mis",   0, 3'b010, 10'h011, 32'h0,        32'h80AD1234, 0);
        access("sh_mis",   1, 3'b001, 10'h021, 32'h0000FFFF, 32'h0,        0);
        access("lw_20",    0, 3'b010, 10'h020, 32'h0,        32'hCAFEFFFF, 0);
`endif
        access("st_f3_011", 1, 3'b011, 10'h020, 32'h0,       32'h0,        1);
        access("sb_f3_100", 1, 3'b100, 10'h020, 32'h11,      32'h0,        1);
        access("ld_f3_011", 0, 3'b011, 10'h020, 32'h0,       32'h0,        1);
        access("ld_f3_110", 0, 3'b110, 10'h020, 32'h0,       32'h0,        1);
`ifdef BYTE_DATA_MEM_MISALIGN_EN
        access("lw_20_kept", 0, 3'b010, 10'h020, 32'h0,      32'hCAFEF00D, 0);
`else
        access("lw_20_kept", 0, 3'b010, 10'h020, 32'h0,      32'hCAFEFFFF, 0);
`endif

        // Back-to-back burst with req_valid held high throughout.
        issue(0, 3'b010, 10'h010, 32'h0);
        issue(1, 3'b010, 10'h030, 32'h89AB8001);
        issue(0, 3'b010, 10'h030, 32'h0);
        issue(0, 3'b001, 10'h030, 32'h0);
        issue(0, 3'b101, 10'h012, 32'h0);
        issue(1, 3'b000, 10'h033, 32'h7F);
        issue(1, 3'b000, 10'h032, 32'h01);
        issue(0, 3'b010, 10'h030, 32'h0);
        expect_rsp("burst_lw", RD_LAT, 32'h7F018001, 0);

        // Reset while a load is waiting.
        issue(0, 3'b010, 10'h010, 32'h0);
        req_valid = 1'b0;
        saved = rsp_count;
        rst = 1'b1;
        pend = 1'b0;
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_busy",  {31'h0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_no_rsp", 32'(rsp_count), 32'(saved));
        acc_count = rsp_count;
        access("lw_30_persist", 0, 3'b010, 10'h030, 32'h0, 32'h7F018001, 0);
        access("lw_10_persist", 0, 3'b010, 10'h010, 32'h0, 32'h80AD1234, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
